// File: rtl/note_sequencer.sv
// Song-table sequencer feeding the square-wave generator.
// Plays ROM entries {note, beats}; beats==0 ends or loops the song.
module note_sequencer #(
    parameter int ADDR_W         = 8,
    parameter int TICKS_PER_BEAT = 6250000,
    parameter int GAP_TICKS      = 250000
) (
    input  logic              clock,
    input  logic              rst_l,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [7:0]        note,
    output logic              playing,
    output logic              beat_pulse,
    output logic              done
);

    localparam int TW = $clog2(TICKS_PER_BEAT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_LOAD  = 2'd2;
    localparam logic [1:0] S_PLAY  = 2'd3;

    localparam logic [31:0] GAP_START =
        32'(TICKS_PER_BEAT - GAP_TICKS);
    localparam logic [TW-1:0] LAST_TICK =
        TW'(TICKS_PER_BEAT - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [7:0]        beats_q, beats_d;
    logic [7:0]        note_q, note_d;
    logic              done_q, done_d;

    logic last_tick;
    logic in_gap;
    logic is_play;

    assign is_play   = (state_q == S_PLAY);
    assign last_tick = (tick_q == LAST_TICK);
    // Silence the tail of the final beat so repeats re-articulate.
    assign in_gap    = (GAP_TICKS != 0)
                    && (beats_q == 8'd1)
                    && (32'(tick_q) >= GAP_START);

    assign rom_addr   = addr_q;
    assign note       = (is_play && !in_gap) ? note_q : 8'd0;
    assign playing    = (state_q != S_IDLE);
    assign beat_pulse = is_play && last_tick;
    assign done       = done_q;

    // Next-state logic for the playback FSM and counters.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        tick_d  = tick_q;
        beats_d = beats_q;
        note_d  = note_q;
        done_d  = 1'b0;
        if (stop) begin
            state_d = S_IDLE;
            addr_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_d  = '0;
                        state_d = S_FETCH;
                    end
                end
                S_FETCH: begin
                    state_d = S_LOAD;
                end
                S_LOAD: begin
                    if (rom_data[7:0] == 8'd0) begin
                        addr_d = '0;
                        if (loop) begin
                            state_d = S_FETCH;
                        end else begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else begin
                        note_d  = rom_data[15:8];
                        beats_d = rom_data[7:0];
                        tick_d  = '0;
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (last_tick) begin
                        tick_d  = '0;
                        beats_d = beats_q - 8'd1;
                        if (beats_q == 8'd1) begin
                            state_d = S_FETCH;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    addr_d  = '0;
                end
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!rst_l) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            tick_q  <= '0;
            beats_q <= 8'd0;
            note_q  <= 8'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            tick_q  <= tick_d;
            beats_q <= beats_d;
            note_q  <= note_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with TICKS_PER_BEAT=4, GAP_TICKS=1.
// A second instance with ADDR_W=2 covers address wrap-around.
module tb_note_sequencer;

    logic        clock = 1'b0;
    logic        rst_l = 1'b0;
    logic        start = 1'b0;
    logic        stop  = 1'b0;
    logic        loop  = 1'b0;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data = 16'd0;
    logic [7:0]  note;
    logic        playing;
    logic        beat_pulse;
    logic        done;

    logic        start2 = 1'b0;
    logic [1:0]  rom_addr2;
    logic [15:0] rom_data2 = 16'd0;
    logic [7:0]  note2;
    logic        playing2;
    logic        beat_pulse2;
    logic        done2;

    logic [15:0] rom1 [0:255];
    logic [15:0] rom2 [0:3];

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    always @(posedge clock) rom_data  <= rom1[rom_addr];
    always @(posedge clock) rom_data2 <= rom2[rom_addr2];

    note_sequencer #(
        .ADDR_W(8), .TICKS_PER_BEAT(4), .GAP_TICKS(1)
    ) dut (
        .clock(clock), .rst_l(rst_l), .start(start),
        .stop(stop), .loop(loop), .rom_addr(rom_addr),
        .rom_data(rom_data), .note(note), .playing(playing),
        .beat_pulse(beat_pulse), .done(done)
    );

    note_sequencer #(
        .ADDR_W(2), .TICKS_PER_BEAT(4), .GAP_TICKS(1)
    ) dut2 (
        .clock(clock), .rst_l(rst_l), .start(start2),
        .stop(1'b0), .loop(1'b0), .rom_addr(rom_addr2),
        .rom_data(rom_data2), .note(note2), .playing(playing2),
        .beat_pulse(beat_pulse2), .done(done2)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        rst_l = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        step();
        step();
        rst_l = 1'b1;
    endtask

    task automatic test_reset();
        rst_l = 1'b0;
        start = 1'b1;
        step();
        step();
        checks++;
        if (note !== 8'd0 || playing !== 1'b0 || rom_addr !== 8'd0
            || done !== 1'b0 || beat_pulse !== 1'b0) begin
            failures++;
            $display("FAIL reset: note=%h playing=%b addr=%h done=%b bp=%b want 0",
                     note, playing, rom_addr, done, beat_pulse);
        end
        start = 1'b0;
        rst_l = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] en;
        logic       eb, ed, ep;
        do_reset();
        loop  = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            en = (c >= 3 && c <= 9) ? 8'h45 : 8'h00;
            eb = (c == 6 || c == 10 || c == 16);
            ed = (c == 19);
            ep = (c >= 1 && c <= 18);
            checks++;
            if (note !== en || beat_pulse !== eb
                || done !== ed || playing !== ep) begin
                failures++;
                $display("FAIL basic c=%0d: note=%h bp=%b done=%b play=%b want %h %b %b %b",
                         c, note, beat_pulse, done, playing, en, eb, ed, ep);
            end
            if (c == 11 || c == 19) begin
                checks++;
                if (rom_addr !== ((c == 11) ? 8'd1 : 8'd0)) begin
                    failures++;
                    $display("FAIL basic_addr c=%0d: got %h want %h",
                             c, rom_addr, (c == 11) ? 8'd1 : 8'd0);
                end
            end
            step();
        end
    endtask

    task automatic test_loop();
        do_reset();
        loop  = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL loop_done c=%0d: got %b want 0", c, done);
            end
            if (c == 19) begin
                checks++;
                if (rom_addr !== 8'd0 || playing !== 1'b1) begin
                    failures++;
                    $display("FAIL loop_addr: addr=%h play=%b want 00 1",
                             rom_addr, playing);
                end
            end
            if (c == 20 || c == 21) begin
                checks++;
                if (note !== ((c == 21) ? 8'h45 : 8'h00)) begin
                    failures++;
                    $display("FAIL loop_note c=%0d: got %h want %h",
                             c, note, (c == 21) ? 8'h45 : 8'h00);
                end
            end
            step();
        end
        loop = 1'b0;
    endtask

    task automatic test_stop();
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c == 5) stop = 1'b1;
            step();
        end
        stop = 1'b0;
        checks++;
        if (note !== 8'd0 || playing !== 1'b0 || rom_addr !== 8'd0
            || done !== 1'b0) begin
            failures++;
            $display("FAIL stop: note=%h play=%b addr=%h done=%b want 0",
                     note, playing, rom_addr, done);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        checks++;
        if (note !== 8'd0 || playing !== 1'b1) begin
            failures++;
            $display("FAIL restart_c2: note=%h play=%b want 00 1",
                     note, playing);
        end
        step();
        checks++;
        if (note !== 8'h45) begin
            failures++;
            $display("FAIL restart_c3: note=%h want 45", note);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 4; c++) step();
        checks++;
        if (note !== 8'h45) begin
            failures++;
            $display("FAIL mid_pre: note=%h want 45", note);
        end
        rst_l = 1'b0;
        step();
        rst_l = 1'b1;
        checks++;
        if (note !== 8'd0 || playing !== 1'b0 || rom_addr !== 8'd0
            || done !== 1'b0 || beat_pulse !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: note=%h play=%b addr=%h done=%b bp=%b want 0",
                     note, playing, rom_addr, done, beat_pulse);
        end
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (playing !== 1'b0 || note !== 8'd0) begin
                failures++;
                $display("FAIL mid_idle c=%0d: play=%b note=%h want 0 00",
                         c, playing, note);
            end
        end
    endtask

    task automatic test_start_stop();
        do_reset();
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        checks++;
        if (playing !== 1'b0 || rom_addr !== 8'd0) begin
            failures++;
            $display("FAIL start_stop: play=%b addr=%h want 0 00",
                     playing, rom_addr);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] en;
        do_reset();
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            checks++;
            if (done2 !== 1'b0) begin
                failures++;
                $display("FAIL wrap_done c=%0d: got %b want 0", c, done2);
            end
            if (c >= 3 && c <= 27 && ((c - 3) % 6) == 0) begin
                en = 8'h10 + 8'(((c - 3) / 6) % 4);
                checks++;
                if (note2 !== en) begin
                    failures++;
                    $display("FAIL wrap_note c=%0d: got %h want %h",
                             c, note2, en);
                end
            end
            if (c == 6) begin
                checks++;
                if (note2 !== 8'd0 || beat_pulse2 !== 1'b1) begin
                    failures++;
                    $display("FAIL wrap_gap: note=%h bp=%b want 00 1",
                             note2, beat_pulse2);
                end
            end
            if (c == 21) begin
                checks++;
                if (rom_addr2 !== 2'd0 || playing2 !== 1'b1) begin
                    failures++;
                    $display("FAIL wrap_addr: addr=%0d play=%b want 0 1",
                             rom_addr2, playing2);
                end
            end
            step();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom1[i] = 16'h0000;
        rom1[0] = {8'h45, 8'd2};
        rom1[1] = {8'h00, 8'd1};
        rom1[2] = {8'h00, 8'd0};
        rom2[0] = {8'h10, 8'd1};
        rom2[1] = {8'h11, 8'd1};
        rom2[2] = {8'h12, 8'd1};
        rom2[3] = {8'h13, 8'd1};
        test_reset();
        test_basic();
        test_loop();
        test_stop();
        test_reset_mid();
        test_start_stop();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
